router_pkt_ctrl: RTL and testbench
==================================

Name: router_pkt_ctrl

Overview:
- Ingress controller of the 1x3 router, sitting directly upstream of the three router_fifo instances.
- Accepts the serial byte stream from the source and decodes the header to select the destination FIFO.
- Drives write_enb/lfd_state/data into that FIFO and back-pressures the source when the FIFO is full.
- Computes running XOR parity and compares it with the trailing parity byte, flagging errors and dropping packets addressed to the invalid port.

Parameters:
- DROP_ADDR, 2'b11, header address value treated as invalid; the packet is consumed and discarded.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pkt_valid  input  1  source byte valid.
- data_in  input  8  source byte: header, payload, then parity.
- fifo_full  input  3  full flags of FIFO0..FIFO2.
- busy  output  1  back-pressure; byte is accepted on a rising edge only when pkt_valid=1 and busy=0.
- data_out  output  8  byte to the FIFOs (shared bus).
- write_enb  output  3  one-hot write enable for FIFO0..FIFO2.
- lfd_state  output  1  high in the cycle the header byte is written.
- parity_done  output  1  one-cycle pulse when the parity check completes.
- err  output  1  parity mismatch flag; held until the next header is accepted.
- pkt_dropped  output  1  one-cycle pulse when a DROP_ADDR packet finishes.

Behaviour:
- Packet format:
  - header = {len[5:0], addr[1:0]}.
  - Followed by len payload bytes (len 0..63), then 1 parity byte.
  - Expected parity = XOR of header and all payload bytes.
- Reset (async, any time):
  - state=IDLE; data_out=0, write_enb=0, lfd_state=0, parity_done=0, err=0, pkt_dropped=0.
  - Internal len counter, addr and parity cleared.
  - Reset mid-packet abandons the packet; the first accepted byte after release is treated as a header.
- States: IDLE, LOAD, CHECK, DROP.
- IDLE:
  - busy = pkt_valid & (data_in[1:0]!=DROP_ADDR) & fifo_full[data_in[1:0]].
  - On accept: latch addr and len, parity<=header, clear err, byte counter<=len+1.
  - addr==DROP_ADDR -> DROP. Otherwise -> LOAD, and the next cycle data_out=header, write_enb[addr]=1, lfd_state=1.
- LOAD:
  - busy = fifo_full[addr].
  - On each accepted byte: data_out<=byte, write_enb[addr]<=1 (1-cycle latency, lfd_state=0), counter decrements.
  - Payload bytes are XORed into parity.
  - The final byte (counter==1) is the parity byte: it is written to the FIFO, compared with the running parity, and the state -> CHECK.
  - Cycles with no accept: write_enb=0, data_out holds its last value.
- CHECK (exactly 1 cycle):
  - busy=1, write_enb=0, parity_done=1.
  - err<=mismatch.
  - -> IDLE.
- DROP:
  - busy=0; accept and discard len+1 bytes, write_enb stays 0.
  - After the last byte: pkt_dropped pulses 1 cycle, err unchanged, -> IDLE.
- write_enb is never multi-hot; at most one FIFO is written per cycle.
- fifo_full rising mid-packet: busy rises combinationally in the same cycle and no byte is lost. The packet resumes when full drops.
- pkt_valid low mid-packet: the controller waits indefinitely in the current state with no timeout.
- len=0: header then parity byte; exactly 2 FIFO writes.
- Total bytes per accepted packet written to the FIFO = len+2; max 65 bytes, the FIFO must be deep enough or rely on busy.

Test Plan:
- Reset, then header 8'h39 (len14, addr1), 14 random bytes, correct parity -> write_enb=3'b010 for 16 cycles, lfd_state only on the first; parity_done pulse; err=0.
- Same packet with parity byte XOR 8'h01 -> all 16 bytes still written to FIFO1; parity_done pulse with err=1; err clears when the next header is accepted.
- Header 8'h0B (len2, addr3), 3 more bytes -> write_enb stays 0; pkt_dropped pulses after the 4th byte; next header 8'h04 (len1, addr0) routes to FIFO0.
- Packet to FIFO2; assert fifo_full[2] for 5 cycles after the 3rd payload byte -> busy=1 during those cycles, no write_enb, no byte lost or duplicated; data order intact.
- Header 8'h02 (len0, addr2) then parity 8'h02 -> exactly 2 writes to FIFO2, err=0; busy=1 in the CHECK cycle.
- Assert reset after the 5th payload byte -> all outputs 0 asynchronously; next byte 8'h05 is decoded as a header (len1, addr1).

Source files
------------

// File: rtl/router_pkt_ctrl_if.sv
// Byte-stream and FIFO-side signals of the 1x3 router ingress controller.
interface router_pkt_ctrl_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic       busy;
  logic [7:0] data_out;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic       parity_done;
  logic       err;
  logic       pkt_dropped;

  // Source/FIFO side (drives the stream and full flags)
  modport master (
    output pkt_valid, data_in, fifo_full,
    input  busy, data_out, write_enb, lfd_state, parity_done, err, pkt_dropped
  );

  // Controller side
  modport slave (
    input  pkt_valid, data_in, fifo_full,
    output busy, data_out, write_enb, lfd_state, parity_done, err, pkt_dropped
  );
endinterface

// File: rtl/router_pkt_ctrl.sv
// Router ingress controller: header decode, FIFO write steering, parity check, drop of invalid-port packets.
module router_pkt_ctrl #(
  parameter logic [1:0] DROP_ADDR = 2'b11
) (
  input  logic              clock,
  input  logic              reset,
  router_pkt_ctrl_if.slave  bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned NF = 3;
  localparam int unsigned CW = 7;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DROP} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_addr, w_addr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_parity, w_parity_nxt;
  logic [DW-1:0] r_data_out, w_data_out_nxt;
  logic [NF-1:0] r_write_enb, w_write_enb_nxt;
  logic          r_lfd, w_lfd_nxt;
  logic          r_pdone, w_pdone_nxt;
  logic          r_err, w_err_nxt;
  logic          r_drop, w_drop_nxt;
  logic          w_busy;
  logic          w_accept;
  logic [1:0]    w_hdr_addr;
  logic [3:0]    w_full_pad;

  // Address 3 has no FIFO; pad the full vector so any 2-bit address indexes safely
  assign w_hdr_addr = bus.data_in[1:0];
  assign w_full_pad = {1'b0, bus.fifo_full};

  function automatic logic [NF-1:0] onehot(input logic [1:0] a);
    logic [3:0] v;
    v = 4'b0001 << a;
    return v[NF-1:0];
  endfunction

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_parity    <= '0;
      r_data_out  <= '0;
      r_write_enb <= '0;
      r_lfd       <= 1'b0;
      r_pdone     <= 1'b0;
      r_err       <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_parity    <= w_parity_nxt;
      r_data_out  <= w_data_out_nxt;
      r_write_enb <= w_write_enb_nxt;
      r_lfd       <= w_lfd_nxt;
      r_pdone     <= w_pdone_nxt;
      r_err       <= w_err_nxt;
      r_drop      <= w_drop_nxt;
    end
  end

  // Next-state, back-pressure and next output values
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_cnt_nxt       = r_cnt;
    w_parity_nxt    = r_parity;
    w_data_out_nxt  = r_data_out;
    w_write_enb_nxt = '0;
    w_lfd_nxt       = 1'b0;
    w_pdone_nxt     = 1'b0;
    w_err_nxt       = r_err;
    w_drop_nxt      = 1'b0;
    w_busy          = 1'b0;
    w_accept        = 1'b0;

    case (r_state)
      IDLE: begin
        w_busy   = bus.pkt_valid & (w_hdr_addr != DROP_ADDR) & w_full_pad[w_hdr_addr];
        w_accept = bus.pkt_valid & ~w_busy;
        if (w_accept) begin
          w_addr_nxt   = w_hdr_addr;
          w_cnt_nxt    = CW'(bus.data_in[7:2]) + CW'(1);
          w_parity_nxt = bus.data_in;
          w_err_nxt    = 1'b0;
          if (w_hdr_addr == DROP_ADDR) begin
            w_state_nxt = DROP;
          end else begin
            w_state_nxt     = LOAD;
            w_data_out_nxt  = bus.data_in;
            w_write_enb_nxt = onehot(w_hdr_addr);
            w_lfd_nxt       = 1'b1;
          end
        end
      end
      LOAD: begin
        w_busy   = w_full_pad[r_addr];
        w_accept = bus.pkt_valid & ~w_busy;
        if (w_accept) begin
          w_data_out_nxt  = bus.data_in;
          w_write_enb_nxt = onehot(r_addr);
          w_cnt_nxt       = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_pdone_nxt = 1'b1;
            w_err_nxt   = (bus.data_in != r_parity);
            w_state_nxt = CHECK;
          end else begin
            w_parity_nxt = r_parity ^ bus.data_in;
          end
        end
      end
      CHECK: begin
        w_busy      = 1'b1;
        w_state_nxt = IDLE;
      end
      DROP: begin
        w_accept = bus.pkt_valid;
        if (w_accept) begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_drop_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.busy        = w_busy;
  assign bus.data_out    = r_data_out;
  assign bus.write_enb   = r_write_enb;
  assign bus.lfd_state   = r_lfd;
  assign bus.parity_done = r_pdone;
  assign bus.err         = r_err;
  assign bus.pkt_dropped = r_drop;

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Directed bench for router_pkt_ctrl: write-stream scoreboard plus pulse/flag checks.
module tb_router_pkt_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;

  router_pkt_ctrl_if bus ();

  router_pkt_ctrl #(.DROP_ADDR(2'b11)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] we;
    logic       lfd;
    logic [7:0] d;
    int         cyc;
  } wr_t;

  wr_t        mon_q[$];
  logic [11:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         pd_cnt   = 0;
  int         drop_cnt = 0;
  int         multihot = 0;
  logic       err_at_pd = 1'b0;
  logic [7:0] pl[64];
  logic [7:0] par_acc;
  logic [2:0] cur_oh;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record every FIFO write and every status pulse
  always @(negedge clock) begin
    cyc++;
    if (bus.write_enb != 3'b000)
      mon_q.push_back('{bus.write_enb, bus.lfd_state, bus.data_out, cyc});
    if (!$onehot0(bus.write_enb)) multihot++;
    if (bus.parity_done) begin
      pd_cnt++;
      err_at_pd = bus.err;
    end
    if (bus.pkt_dropped) drop_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.pkt_valid = 1'b1;
    bus.data_in   = b;
    #1;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("accept_wait", 32'(n >= 100), 32'd0);
    @(posedge clock);
    @(negedge clock);
    bus.pkt_valid = 1'b0;
  endtask

  task automatic pkt_head(input logic [7:0] hdr);
    cur_oh  = (hdr[1:0] == 2'b11) ? 3'b000 : 3'(4'b0001 << hdr[1:0]);
    par_acc = hdr;
    if (cur_oh != 3'b000) exp_q.push_back({cur_oh, 1'b1, hdr});
    send_byte(hdr);
  endtask

  task automatic pkt_body(input logic [7:0] b);
    par_acc = par_acc ^ b;
    if (cur_oh != 3'b000) exp_q.push_back({cur_oh, 1'b0, b});
    send_byte(b);
  endtask

  task automatic pkt_tail(input logic [7:0] flip);
    logic [7:0] p;
    p = par_acc ^ flip;
    if (cur_oh != 3'b000) exp_q.push_back({cur_oh, 1'b0, p});
    send_byte(p);
  endtask

  task automatic verify(input string tag, input bit contig);
    repeat (2) @(negedge clock);
    #1;
    chk({tag, "_nwr"}, 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'({mon_q[i].we, mon_q[i].lfd, mon_q[i].d}), 32'(exp_q[i]));
    if (contig && mon_q.size() > 0)
      chk({tag, "_contig"}, 32'(mon_q[mon_q.size()-1].cyc - mon_q[0].cyc + 1), 32'(mon_q.size()));
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_data_out"},    32'(bus.data_out),    32'd0);
    chk({tag, "_write_enb"},   32'(bus.write_enb),   32'd0);
    chk({tag, "_lfd_state"},   32'(bus.lfd_state),   32'd0);
    chk({tag, "_parity_done"}, 32'(bus.parity_done), 32'd0);
    chk({tag, "_err"},         32'(bus.err),         32'd0);
    chk({tag, "_pkt_dropped"}, 32'(bus.pkt_dropped), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pkt_valid = 1'b0;
    bus.data_in   = 8'h00;
    bus.fifo_full = 3'b000;
    for (int i = 0; i < 64; i++) pl[i] = 8'((i * 37 + 11) ^ (i << 3));

    // Reset state
    #12;
    chk_outs_zero("reset");
    chk("reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // len14 to FIFO1, good parity
    pkt_head(8'h39);
    for (int i = 0; i < 14; i++) pkt_body(pl[i]);
    pkt_tail(8'h00);
    verify("p1", 1'b1);
    chk("p1_pd_cnt", 32'(pd_cnt), 32'd1);
    chk("p1_err_at_pd", 32'(err_at_pd), 32'd0);

    // Same packet, corrupted parity byte
    pkt_head(8'h39);
    for (int i = 0; i < 14; i++) pkt_body(pl[i]);
    pkt_tail(8'h01);
    verify("p2", 1'b1);
    chk("p2_pd_cnt", 32'(pd_cnt), 32'd2);
    chk("p2_err_at_pd", 32'(err_at_pd), 32'd1);
    chk("p2_err_held", 32'(bus.err), 32'd1);

    // Invalid address: consumed, never written; err cleared by the header
    pkt_head(8'h0B);
    chk("drop_err_clr", 32'(bus.err), 32'd0);
    pkt_body(pl[20]);
    pkt_body(pl[21]);
    pkt_tail(8'h00);
    chk("drop_pulse", 32'(bus.pkt_dropped), 32'd1);
    verify("drop", 1'b0);
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
    chk("drop_no_pd", 32'(pd_cnt), 32'd2);

    // len1 to FIFO0 right after the drop
    pkt_head(8'h04);
    pkt_body(pl[30]);
    pkt_tail(8'h00);
    verify("p4", 1'b1);
    chk("p4_pd_cnt", 32'(pd_cnt), 32'd3);
    chk("p4_err_at_pd", 32'(err_at_pd), 32'd0);

    // len7 to FIFO2 with FIFO2 full for 5 cycles after the 3rd payload byte
    pkt_head(8'h1E);
    for (int i = 0; i < 3; i++) pkt_body(pl[i]);
    bus.fifo_full = 3'b100;
    bus.pkt_valid = 1'b1;
    bus.data_in   = pl[3];
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("full_busy%0d", i), 32'(bus.busy), 32'd1);
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("full_nowr%0d", i), 32'(bus.write_enb), 32'd0);
    end
    bus.fifo_full = 3'b000;
    for (int i = 3; i < 7; i++) pkt_body(pl[i]);
    pkt_tail(8'h00);
    verify("full", 1'b0);
    chk("full_pd_cnt", 32'(pd_cnt), 32'd4);
    chk("full_err_at_pd", 32'(err_at_pd), 32'd0);

    // len0 to FIFO2: header + parity 8'h02
    pkt_head(8'h02);
    pkt_tail(8'h00);
    chk("len0_check_busy", 32'(bus.busy), 32'd1);
    chk("len0_pdone", 32'(bus.parity_done), 32'd1);
    verify("len0", 1'b1);
    chk("len0_pd_cnt", 32'(pd_cnt), 32'd5);
    chk("len0_err_at_pd", 32'(err_at_pd), 32'd0);

    // Reset after the 5th payload byte, then 8'h05 must decode as a header
    pkt_head(8'h1D);
    for (int i = 10; i < 15; i++) pkt_body(pl[i]);
    #2;
    reset = 1'b1;
    #1;
    chk_outs_zero("midrst");
    @(negedge clock);
    mon_q.delete();
    exp_q.delete();
    reset = 1'b0;
    pkt_head(8'h05);
    pkt_body(pl[40]);
    pkt_tail(8'h00);
    verify("rst", 1'b1);
    chk("rst_pd_cnt", 32'(pd_cnt), 32'd6);
    chk("rst_err_at_pd", 32'(err_at_pd), 32'd0);

    chk("multihot", 32'(multihot), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
